// File: rtl/adder_axis_accum.sv
// -----------------------------------------------------------------------------
// adder_axis_accum
//
// Downstream stage of the AXI-Stream adder. Sums ACC_LEN consecutive input beats
// into one output beat and flags, on tuser, any carry out of the accumulator
// within that frame. The accumulate register and the output holding register
// are separate, so the next frame keeps accumulating while a finished result
// waits for the sink. Only the final beat of a frame is ever stalled.
//
// Build option:
//   ADDER_ACCUM_SATURATE_EN  defined  : accumulator clamps to 2^ACC_W-1 on overflow
//                            undefined: accumulator wraps modulo 2^ACC_W
//   tuser flags the overflow in both builds.
//
// Parameters:
//   DATA_W   width of the unsigned input sums
//   ACC_LEN  input beats per output frame (>= 1)
//   ACC_W    accumulator / result width (>= DATA_W)
//
// Ports:
//   aclk           in   clock, rising edge
//   areset         in   asynchronous reset, active-high
//   s_data_tdata   in   input sum (DATA_W)
//   s_data_tvalid  in   input valid
//   s_data_tready  out  input ready (combinational on m_data_tready only)
//   m_data_tdata   out  accumulated frame result (ACC_W)
//   m_data_tuser   out  overflow occurred within this frame
//   m_data_tvalid  out  output valid
//   m_data_tready  in   sink ready
// -----------------------------------------------------------------------------
module adder_axis_accum #(
   parameter int DATA_W  = 16,
   parameter int ACC_LEN = 16,
   parameter int ACC_W   = 20
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic [DATA_W-1:0] s_data_tdata,
   input  logic              s_data_tvalid,
   output logic              s_data_tready,
   output logic [ACC_W-1:0]  m_data_tdata,
   output logic              m_data_tuser,
   output logic              m_data_tvalid,
   input  logic              m_data_tready
);

   localparam int               CNT_W    = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

   logic [CNT_W-1:0] cnt;
   logic [ACC_W-1:0] acc;
   logic             frame_ovf;

   logic             last_beat;
   logic             in_hs;
   logic [ACC_W-1:0] acc_base;
   logic [ACC_W:0]   sum_ext;
   logic             sum_ovf;
   logic [ACC_W-1:0] acc_nxt;
   logic             frame_ovf_nxt;

   // Reduce the ACC_W+1 wide sum back to ACC_W bits: clamp or wrap.
   function automatic logic [ACC_W-1:0] clamp_sum(input logic [ACC_W:0] s);
`ifdef ADDER_ACCUM_SATURATE_EN
      // Once clamped, any further non-zero add overflows again, so the
      // accumulator stays pinned at full scale for the rest of the frame.
      if (s[ACC_W])
         clamp_sum = '1;
      else
         clamp_sum = s[ACC_W-1:0];
`else
      clamp_sum = s[ACC_W-1:0];
`endif
   endfunction

   assign last_beat     = (cnt == CNT_LAST);
   // Only the frame-closing beat needs the holding register, so only it waits.
   assign s_data_tready = !(last_beat && m_data_tvalid && !m_data_tready);
   assign in_hs         = s_data_tvalid && s_data_tready;

   // First beat of a frame starts from zero rather than the stale accumulator.
   assign acc_base      = (cnt == '0) ? '0 : acc;
   assign sum_ext       = {1'b0, acc_base} + {{(ACC_W + 1 - DATA_W){1'b0}}, s_data_tdata};
   assign sum_ovf       = sum_ext[ACC_W];
   assign acc_nxt       = clamp_sum(sum_ext);
   assign frame_ovf_nxt = (cnt == '0) ? sum_ovf : (frame_ovf || sum_ovf);

   // Accumulate stage and output holding register
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         cnt           <= '0;
         acc           <= '0;
         frame_ovf     <= 1'b0;
         m_data_tdata  <= '0;
         m_data_tuser  <= 1'b0;
         m_data_tvalid <= 1'b0;
      end else begin
         if (in_hs) begin
            acc       <= acc_nxt;
            frame_ovf <= frame_ovf_nxt;
            if (last_beat) begin
               cnt          <= '0;
               m_data_tdata <= acc_nxt;
               m_data_tuser <= frame_ovf_nxt;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
         // A new result loading in the same cycle as a sink handshake keeps
         // valid high; otherwise a handshake clears it.
         if (in_hs && last_beat)
            m_data_tvalid <= 1'b1;
         else if (m_data_tready)
            m_data_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_axis_accum.sv
// -----------------------------------------------------------------------------
// tb_adder_axis_accum
//
// Directed bench for adder_axis_accum. Three instances share clock and reset:
//   dut4 : DATA_W=16, ACC_W=20, ACC_LEN=4
//   dut2 : DATA_W=8,  ACC_W=8,  ACC_LEN=2  (overflow behaviour)
//   dut1 : DATA_W=16, ACC_W=20, ACC_LEN=1  (registered pass-through)
// Inputs change 1 ns after the rising edge; outputs are sampled after that.
// -----------------------------------------------------------------------------
module tb_adder_axis_accum;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        areset;

   logic [15:0] d4;
   logic [19:0] q4;
   logic        v4, r4, t4, mv4, mr4;

   logic [7:0]  d2, q2;
   logic        v2, r2, t2, mv2, mr2;

   logic [15:0] d1;
   logic [19:0] q1;
   logic        v1, r1, t1, mv1, mr1;

`ifdef ADDER_ACCUM_SATURATE_EN
   localparam logic [7:0] OVF_EXP = 8'd255;
`else
   localparam logic [7:0] OVF_EXP = 8'd44;
`endif

   adder_axis_accum #(.DATA_W(16), .ACC_LEN(4), .ACC_W(20)) dut4 (
      .aclk(clk), .areset(areset),
      .s_data_tdata(d4), .s_data_tvalid(v4), .s_data_tready(r4),
      .m_data_tdata(q4), .m_data_tuser(t4), .m_data_tvalid(mv4), .m_data_tready(mr4)
   );

   adder_axis_accum #(.DATA_W(8), .ACC_LEN(2), .ACC_W(8)) dut2 (
      .aclk(clk), .areset(areset),
      .s_data_tdata(d2), .s_data_tvalid(v2), .s_data_tready(r2),
      .m_data_tdata(q2), .m_data_tuser(t2), .m_data_tvalid(mv2), .m_data_tready(mr2)
   );

   adder_axis_accum #(.DATA_W(16), .ACC_LEN(1), .ACC_W(20)) dut1 (
      .aclk(clk), .areset(areset),
      .s_data_tdata(d1), .s_data_tvalid(v1), .s_data_tready(r1),
      .m_data_tdata(q1), .m_data_tuser(t1), .m_data_tvalid(mv1), .m_data_tready(mr1)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] sb[$];
   int          n_in;
   int          n_out;
   logic [15:0] prev_d;

   initial begin
      areset = 1'b1;
      d4 = '0; v4 = 1'b0; mr4 = 1'b1;
      d2 = '0; v2 = 1'b0; mr2 = 1'b1;
      d1 = '0; v1 = 1'b0; mr1 = 1'b1;
      repeat (2) step();

      // reset state
      check("rst_mv4", mv4, 0);
      check("rst_q4", q4, 0);
      check("rst_t4", t4, 0);
      check("rst_mv2", mv2, 0);
      check("rst_mv1", mv1, 0);
      @(negedge clk) areset = 1'b0;
      step();
      check("rel_r4", r4, 1);
      check("rel_r2", r2, 1);
      check("rel_r1", r1, 1);

      // 1,2,3,4 back-to-back with sink ready
      for (int i = 0; i < 4; i++) begin
         v4 = 1'b1;
         d4 = 16'(i + 1);
         #1;
         check("t2_rdy", r4, 1);
         check("t2_idle", mv4, 0);
         step();
      end
      v4 = 1'b0;
      check("t2_mv", mv4, 1);
      check("t2_q", q4, 10);
      check("t2_t", t4, 0);
      step();
      check("t2_drop", mv4, 0);

      // sink stalled, eight beats of 5
      mr4 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         v4 = 1'b1;
         d4 = 16'd5;
         #1;
         check("t3_rdy", r4, 1);
         step();
         if (i >= 3) begin
            check("t3_hold_mv", mv4, 1);
            check("t3_hold_q", q4, 20);
         end
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         check("t3_stall", r4, 0);
         check("t3_stall_q", q4, 20);
         step();
      end
      mr4 = 1'b1;
      #1;
      check("t3_unstall", r4, 1);
      step();
      v4 = 1'b0;
      check("t3_mv2", mv4, 1);
      check("t3_q2", q4, 20);
      check("t3_t2", t4, 0);
      step();
      check("t3_drop", mv4, 0);

      // 8-bit overflow, then a clean frame
      v2 = 1'b1; d2 = 8'd200; step();
      d2 = 8'd100; step();
      v2 = 1'b0;
      check("t4_mv", mv2, 1);
      check("t4_q", q2, OVF_EXP);
      check("t4_t", t2, 1);
      v2 = 1'b1; d2 = 8'd1; step();
      step();
      v2 = 1'b0;
      check("t4_mv_b", mv2, 1);
      check("t4_q_b", q2, 2);
      check("t4_t_b", t2, 0);
      step();
      check("t4_drop", mv2, 0);

      // leave results pending on dut4 and dut2, then reset mid-operation
      mr2 = 1'b0;
      v2 = 1'b1; d2 = 8'd200; step();
      d2 = 8'd100; step();
      v2 = 1'b0;
      mr4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v4 = 1'b1; d4 = 16'd3; step();
      end
      v4 = 1'b0;
      check("t1_pre_q4", q4, 12);
      check("t1_pre_t2", t2, 1);
      #2 areset = 1'b1;
      #1;
      check("t1_mv4", mv4, 0);
      check("t1_q4", q4, 0);
      check("t1_mv2", mv2, 0);
      check("t1_q2", q2, 0);
      check("t1_t2", t2, 0);
      @(negedge clk) areset = 1'b0;
      mr4 = 1'b1;
      mr2 = 1'b1;
      step();
      check("t1_r4", r4, 1);
      check("t1_r2", r2, 1);
      check("t1_mv4_post", mv4, 0);

      // partial frame discarded by reset
      v4 = 1'b1; d4 = 16'd7; step();
      step();
      v4 = 1'b0;
      #2 areset = 1'b1;
      @(negedge clk) areset = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         v4 = 1'b1; d4 = 16'd1;
         #1;
         check("t5_idle", mv4, 0);
         step();
      end
      v4 = 1'b0;
      check("t5_mv", mv4, 1);
      check("t5_q", q4, 4);
      check("t5_t", t4, 0);
      step();

      // ACC_LEN=1 random handshakes
      n_in = 0;
      n_out = 0;
      for (int c = 0; c < 6000 && n_in < 1000; c++) begin
         v1  = ($urandom_range(0, 3) != 0);
         d1  = 16'($urandom_range(0, 65535));
         mr1 = ($urandom_range(0, 3) != 0);
         #1;
         if (mv1 && mr1) begin
            check("t6_have", (sb.size() > 0), 1);
            if (sb.size() > 0) check("t6_data", q1, sb.pop_front());
            n_out++;
         end
         if (v1 && r1) begin
            sb.push_back(d1);
            n_in++;
         end
         step();
      end
      v1 = 1'b0;
      mr1 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (mv1 && mr1) begin
            check("t6_have", (sb.size() > 0), 1);
            if (sb.size() > 0) check("t6_data", q1, sb.pop_front());
            n_out++;
         end
         step();
      end
      check("t6_nin", n_in, 1000);
      check("t6_count", n_out, n_in);
      check("t6_left", sb.size(), 0);

      // full rate with both sides always ready
      v1 = 1'b1;
      mr1 = 1'b1;
      prev_d = '0;
      for (int c = 0; c < 20; c++) begin
         d1 = 16'(c * 7 + 3);
         #1;
         check("t6_rate_rdy", r1, 1);
         if (c > 0) begin
            check("t6_rate_mv", mv1, 1);
            check("t6_rate_q", q1, prev_d);
         end
         prev_d = d1;
         step();
      end
      v1 = 1'b0;
      check("t6_rate_last", q1, prev_d);
      step();
      check("t6_rate_drop", mv1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
